// File: rtl/msp430_pkg.sv
// Shared constants for the extension-word fetch path: addressing-mode
// codes, fetch FSM state encoding and the PC step between words.
package msp430_pkg;

    localparam logic [2:0] AM_IDX_S  = 3'b001;
    localparam logic [2:0] AM_IDX_D  = 3'b100;
    localparam logic [2:0] AM_IDX_SD = 3'b101;

    localparam int PC_STEP = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        PRESENT1 = 3'd2,
        HOLD1    = 3'd3,
        HOLD2    = 3'd4,
        FINISH   = 3'd5
    } state_e;

    // Number of extension words implied by the {Ad,As} mode bits.
    function automatic logic [1:0] word_count(input logic [2:0] am);
        case (am)
            AM_IDX_S:  word_count = 2'd1;
            AM_IDX_D:  word_count = 2'd1;
            AM_IDX_SD: word_count = 2'd2;
            default:   word_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ext_word_fetch.sv
// Extension-word fetcher: reads up to two index words at PC, then hands
// them to calc one at a time behind an MC strobe and reports the new PC.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; outputs hold their last values
// FETCH    | mem_rd asserted, collecting words until the count is reached
// PRESENT1 | MDB_out carries w0, MC pulses for this single cycle
// HOLD1    | w0 held until calc signals CALC_done
// HOLD2    | w1 held until calc signals CALC_done (two-word mode only)
// FINISH   | PC_out valid, PC_wr pulses for this single cycle
module ext_word_fetch
    import msp430_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    AdAs,
    input  logic [AW-1:0] PC_in,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [DW-1:0] MDB_out,
    output logic          MC,
    input  logic          CALC_done,
    output logic [AW-1:0] PC_out,
    output logic          PC_wr,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [2:0]    am_q, am_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] w0_q, w0_d;
    logic [DW-1:0] w1_q, w1_d;
    logic          idx_q, idx_d;
    logic [DW-1:0] mdb_q, mdb_d;
    logic [AW-1:0] pc_out_q, pc_out_d;
    logic [1:0]    n_words;
    logic          last_word;

    assign n_words   = word_count(am_q);
    assign last_word = ({1'b0, idx_q} == (n_words - 2'd1));

    // State and datapath registers; reset clears the word buffer too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            am_q     <= '0;
            addr_q   <= '0;
            w0_q     <= '0;
            w1_q     <= '0;
            idx_q    <= 1'b0;
            mdb_q    <= '0;
            pc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            am_q     <= am_d;
            addr_q   <= addr_d;
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            idx_q    <= idx_d;
            mdb_q    <= mdb_d;
            pc_out_q <= pc_out_d;
        end
    end

    // Next-state and datapath updates; MDB_out is registered on entry to
    // PRESENT1 so it is already stable while MC is high.
    always_comb begin
        state_d  = state_q;
        am_d     = am_q;
        addr_d   = addr_q;
        w0_d     = w0_q;
        w1_d     = w1_q;
        idx_d    = idx_q;
        mdb_d    = mdb_q;
        pc_out_d = pc_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    am_d   = AdAs;
                    addr_d = PC_in;
                    idx_d  = 1'b0;
                    if (word_count(AdAs) == 2'd0) begin
                        state_d  = FINISH;
                        pc_out_d = PC_in;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    if (idx_q) w1_d = mem_rdata;
                    else       w0_d = mem_rdata;
                    addr_d = addr_q + AW'(PC_STEP);
                    idx_d  = ~idx_q;
                    if (last_word) begin
                        state_d = PRESENT1;
                        // the final word may be w0 itself, still in flight
                        mdb_d   = idx_q ? w0_q : mem_rdata;
                    end
                end
            end
            PRESENT1: begin
                state_d = HOLD1;
            end
            HOLD1: begin
                if (CALC_done) begin
                    if (n_words == 2'd2) begin
                        mdb_d   = w1_q;
                        state_d = HOLD2;
                    end else begin
                        pc_out_d = addr_q;
                        state_d  = FINISH;
                    end
                end
            end
            HOLD2: begin
                if (CALC_done) begin
                    pc_out_d = addr_q;
                    state_d  = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr = addr_q;
    assign mem_rd   = (state_q == FETCH);
    assign MDB_out  = mdb_q;
    assign MC       = (state_q == PRESENT1);
    assign PC_out   = pc_out_q;
    assign PC_wr    = (state_q == FINISH);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ext_word_fetch.sv
// Self-checking bench for ext_word_fetch: a memory responder with
// programmable wait states, a calc-like consumer, and a reference model
// that predicts reads, presented words and the final PC per transaction.
module tb_ext_word_fetch;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  AdAs;
    logic [15:0] PC_in;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] MDB_out;
    logic        MC;
    logic        CALC_done;
    logic [15:0] PC_out;
    logic        PC_wr;
    logic        busy;

    ext_word_fetch #(.AW(16), .DW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .AdAs      (AdAs),
        .PC_in     (PC_in),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .MDB_out   (MDB_out),
        .MC        (MC),
        .CALC_done (CALC_done),
        .PC_out    (PC_out),
        .PC_wr     (PC_wr),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mem [0:65535];
    logic [15:0] rd_log [$];
    int          wait_states = 0;
    bit          stray_ready = 0;
    int          wcnt = 0;
    int          mc_cnt = 0;
    int          pcwr_cnt = 0;
    logic [15:0] exp_mdb = 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Extension words needed by an {Ad,As} mode: indexed source and
    // indexed destination each take one word.
    function automatic int ref_count(input logic [2:0] m);
        return (m[0] & (m[2:1] == 2'b00) ? 1 : 0) + (m[2] & (m[1:0] == 2'b00) ? 1 : 0)
             + ((m == 3'b101) ? 2 : 0);
    endfunction

    // Memory with wait states; logs each address actually handed over.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (mem_rd) begin
                if (wcnt >= wait_states) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr];
                    rd_log.push_back(mem_addr);
                    wcnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 16'($urandom);
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                mem_ready = stray_ready ? 1'($urandom) : 1'b0;
                mem_rdata = 16'($urandom);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (MC) mc_cnt++;
            if (PC_wr) pcwr_cnt++;
        end
    end

    task automatic run_txn(input logic [2:0] mode, input logic [15:0] pc, input int waits);
        int n, t, mc0, pw0;
        logic [15:0] a0, a1, e0, e1, epc;
        n   = ref_count(mode);
        a0  = pc;
        a1  = pc + 16'd2;
        e0  = mem[a0];
        e1  = mem[a1];
        epc = pc + 16'(2 * n);
        rd_log.delete();
        wait_states = waits;
        mc0 = mc_cnt;
        pw0 = pcwr_cnt;
        step();
        start = 1'b1;
        AdAs  = mode;
        PC_in = pc;
        step();
        start = 1'b0;
        AdAs  = 3'($urandom);
        PC_in = 16'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        if (n > 0) begin
            t = 0;
            while (!MC && t < 300) begin
                step();
                t++;
            end
            check("mc_seen", 32'(MC), 32'd1);
            check("reads_before_mc", 32'(rd_log.size()), 32'(n));
            if (rd_log.size() > 0) check("rd_addr0", 32'(rd_log[0]), 32'(a0));
            if (n == 2 && rd_log.size() > 1) check("rd_addr1", 32'(rd_log[1]), 32'(a1));
            check("mdb_w0", 32'(MDB_out), 32'(e0));
            step();
            check("mc_one_cycle", 32'(MC), 32'd0);
            start = 1'b1;
            AdAs  = 3'b101;
            PC_in = 16'($urandom);
            step();
            start = 1'b0;
            repeat ($urandom_range(0, 3)) step();
            check("mdb_hold_w0", 32'(MDB_out), 32'(e0));
            exp_mdb = e0;
            CALC_done = 1'b1;
            step();
            CALC_done = 1'b0;
            if (n == 2) begin
                check("mdb_w1", 32'(MDB_out), 32'(e1));
                repeat ($urandom_range(0, 3)) step();
                check("mdb_hold_w1", 32'(MDB_out), 32'(e1));
                exp_mdb = e1;
                CALC_done = 1'b1;
                step();
                CALC_done = 1'b0;
            end
        end
        t = 0;
        while (!PC_wr && t < 10) begin
            step();
            t++;
        end
        check("pc_wr_seen", 32'(PC_wr), 32'd1);
        check("pc_out", 32'(PC_out), 32'(epc));
        step();
        check("pc_wr_one_cycle", 32'(PC_wr), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("mc_count", 32'(mc_cnt - mc0), (n > 0) ? 32'd1 : 32'd0);
        check("pcwr_count", 32'(pcwr_cnt - pw0), 32'd1);
        check("reads_total", 32'(rd_log.size()), 32'(n));
        check("mdb_kept", 32'(MDB_out), 32'(exp_mdb));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t, pw0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0100] = 16'h0010;
        mem[16'h0200] = 16'h0004;
        mem[16'h0202] = 16'h0008;

        rst_n     = 1'b0;
        start     = 1'b0;
        AdAs      = 3'b000;
        PC_in     = 16'h0000;
        CALC_done = 1'b0;
        repeat (3) step();
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mdb", 32'(MDB_out), 32'd0);
        check("rst_mc", 32'(MC), 32'd0);
        check("rst_pc_out", 32'(PC_out), 32'd0);
        check("rst_pc_wr", 32'(PC_wr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        CALC_done = 1'b1;
        step();
        CALC_done = 1'b0;
        step();
        check("idle_calc_done_busy", 32'(busy), 32'd0);
        check("idle_calc_done_mdb", 32'(MDB_out), 32'd0);
        check("idle_calc_done_mc", 32'(mc_cnt), 32'd0);

        run_txn(3'b001, 16'h0100, 0);
        run_txn(3'b101, 16'h0200, 3);
        run_txn(3'b010, 16'h1234, 0);
        run_txn(3'b101, 16'hFFFE, 1);

        // Reset in the middle of a fetch.
        rd_log.delete();
        wait_states = 6;
        pw0 = pcwr_cnt;
        step();
        start = 1'b1;
        AdAs  = 3'b101;
        PC_in = 16'h4000;
        step();
        start = 1'b0;
        t = 0;
        while (!mem_rd && t < 20) begin
            step();
            t++;
        end
        check("abort_in_fetch", 32'(mem_rd), 32'd1);
        step();
        rst_n = 1'b0;
        #1;
        check("abort_mem_rd", 32'(mem_rd), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_mdb", 32'(MDB_out), 32'd0);
        check("abort_pc_out", 32'(PC_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        exp_mdb = 16'h0000;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        check("abort_no_pc_wr", 32'(pcwr_cnt - pw0), 32'd0);
        run_txn(3'b100, 16'h3000, 2);

        stray_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            run_txn(3'($urandom), 16'($urandom), int'($urandom_range(0, 4)));
        end
        stray_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
